// File: rtl/prei_org_buf_ctrl.sv
// Original-pixel buffer controller for the pre-intra stage: packs a raster 8x8
// block into 16 words of 32 bits, then bursts them back out to the datapath on request.
module prei_org_buf_ctrl #(
    parameter int PIX_WD    = 8,
    parameter int BLK_WORDS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_val_i,
    input  logic [PIX_WD-1:0]     pix_dat_i,
    output logic                  pix_rdy_o,
    output logic                  buf_full_o,
    input  logic                  rd_req_i,
    output logic                  wr_ena_o,
    output logic [3:0]            wr_adr_o,
    output logic [4*PIX_WD-1:0]   wr_dat_o,
    output logic                  rd_ena_o,
    output logic [3:0]            rd_adr_o,
    input  logic [4*PIX_WD-1:0]   rd_dat_i,
    output logic                  org_val_o,
    output logic [3:0]            org_adr_o,
    output logic [4*PIX_WD-1:0]   org_dat_o,
    output logic                  done_o
);

    localparam logic [3:0] LAST_ADR = 4'(BLK_WORDS - 1);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_FULL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_lane;
    logic [3:0]           r_wcnt;
    logic [4*PIX_WD-1:0]  r_pack;
    logic                 r_wr_ena;
    logic [3:0]           r_wr_adr;
    logic [4*PIX_WD-1:0]  r_wr_dat;
    logic                 r_rd_ena;
    logic [3:0]           r_rd_adr;
    logic                 r_org_val;
    logic [3:0]           r_org_adr;
    logic                 r_done;
    logic                 w_acc;
    logic                 w_start;

    // Pixel handshake: a pixel transfers on a cycle where pix_val_i and pix_rdy_o are both high.
    assign w_acc   = pix_val_i & pix_rdy_o;
    assign w_start = (r_state == ST_FULL) & rd_req_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_FILL;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FILL:  if (w_acc && r_lane == 2'd3 && r_wcnt == LAST_ADR) w_state_nxt = ST_FULL;
            ST_FULL:  if (rd_req_i) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (!r_rd_ena && r_rd_adr == LAST_ADR) w_state_nxt = ST_FILL;
            default:  w_state_nxt = ST_FILL;
        endcase
    end

    // The done cycle already sits in FILL, but intake resumes only one cycle later.
    always_comb begin
        pix_rdy_o  = 1'b0;
        buf_full_o = 1'b0;
        case (r_state)
            ST_FILL:  pix_rdy_o  = ~r_done;
            ST_FULL:  buf_full_o = 1'b1;
            ST_DRAIN: buf_full_o = 1'b1;
            default: begin
                pix_rdy_o  = 1'b0;
                buf_full_o = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lane   <= 2'd0;
            r_wcnt   <= 4'd0;
            r_pack   <= '0;
            r_wr_ena <= 1'b1;
            r_wr_adr <= 4'd0;
            r_wr_dat <= '0;
        end else begin
            r_wr_ena <= 1'b1;
            if (w_acc) begin
                r_lane <= r_lane + 2'd1;
                case (r_lane)
                    2'd0: r_pack[4*PIX_WD-1:3*PIX_WD] <= pix_dat_i;
                    2'd1: r_pack[3*PIX_WD-1:2*PIX_WD] <= pix_dat_i;
                    2'd2: r_pack[2*PIX_WD-1:PIX_WD]   <= pix_dat_i;
                    default: begin
                        r_wr_ena <= 1'b0;
                        r_wr_adr <= r_wcnt;
                        r_wr_dat <= {r_pack[4*PIX_WD-1:PIX_WD], pix_dat_i};
                        r_wcnt   <= r_wcnt + 4'd1;
                    end
                endcase
            end
        end
    end

    // Read burst: one address per cycle, the word comes back on rd_dat_i the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ena  <= 1'b1;
            r_rd_adr  <= 4'd0;
            r_org_val <= 1'b0;
            r_org_adr <= 4'd0;
            r_done    <= 1'b0;
        end else begin
            r_org_val <= ~r_rd_ena;
            r_done    <= ~r_rd_ena & (r_rd_adr == LAST_ADR);
            if (!r_rd_ena) begin
                r_org_adr <= r_rd_adr;
                r_rd_adr  <= r_rd_adr + 4'd1;
                if (r_rd_adr == LAST_ADR) r_rd_ena <= 1'b1;
            end else if (w_start) begin
                r_rd_ena <= 1'b0;
            end
        end
    end

    assign wr_ena_o  = r_wr_ena;
    assign wr_adr_o  = r_wr_adr;
    assign wr_dat_o  = r_wr_dat;
    assign rd_ena_o  = r_rd_ena;
    assign rd_adr_o  = r_rd_adr;
    assign org_val_o = r_org_val;
    assign org_adr_o = r_org_adr;
    assign org_dat_o = r_org_val ? rd_dat_i : '0;
    assign done_o    = r_done;

endmodule

// File: tb/tb_prei_org_buf_ctrl.sv
// Bench for prei_org_buf_ctrl: random/sequential pixel streams and drain requests,
// with a cycle-accurate reference of the block transfer rules and a buffer RAM model.
module tb_prei_org_buf_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_val_i = 1'b0;
    logic [7:0]  pix_dat_i = 8'd0;
    logic        pix_rdy_o;
    logic        buf_full_o;
    logic        rd_req_i = 1'b0;
    logic        wr_ena_o;
    logic [3:0]  wr_adr_o;
    logic [31:0] wr_dat_o;
    logic        rd_ena_o;
    logic [3:0]  rd_adr_o;
    logic [31:0] rd_dat_i = 32'd0;
    logic        org_val_o;
    logic [3:0]  org_adr_o;
    logic [31:0] org_dat_o;
    logic        done_o;

    prei_org_buf_ctrl #(.PIX_WD(8), .BLK_WORDS(16)) dut (
        .clk(clk), .rst(rst),
        .pix_val_i(pix_val_i), .pix_dat_i(pix_dat_i), .pix_rdy_o(pix_rdy_o),
        .buf_full_o(buf_full_o), .rd_req_i(rd_req_i),
        .wr_ena_o(wr_ena_o), .wr_adr_o(wr_adr_o), .wr_dat_o(wr_dat_o),
        .rd_ena_o(rd_ena_o), .rd_adr_o(rd_adr_o), .rd_dat_i(rd_dat_i),
        .org_val_o(org_val_o), .org_adr_o(org_adr_o), .org_dat_o(org_dat_o),
        .done_o(done_o)
    );

    // ---------------- clock / cycle count / buffer RAM ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] ram [16];
    always @(posedge clk) begin
        if (!wr_ena_o) ram[wr_adr_o] <= wr_dat_o;
        if (!rd_ena_o) rd_dat_i <= ram[rd_adr_o];
    end

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [3:0]  adr;
        logic [31:0] dat;
        bit          done;
        int          cyc;
    } exp_t;

    exp_t        wr_q[$];
    exp_t        org_q[$];
    logic [7:0]  px_q[$];
    logic [31:0] mem_m [16];
    int          wadr_m   = 0;
    bit          blk_full = 1'b0;
    int          ready_at = -1;
    bit          acc_flag = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        wr_q.delete();
        org_q.delete();
        px_q.delete();
        wadr_m   = 0;
        blk_full = 1'b0;
        ready_at = -1;
        acc_flag = 1'b0;
    endtask

    // ---------------- monitor + reference model ----------------
    always @(negedge clk) begin : monitor
        bit   exp_rdy, exp_full, exp_rd, exp_wr, exp_org, acc;
        exp_t e;
        if (rst) begin
            chk("rst_wr_ena", {31'd0, wr_ena_o}, 32'd1);
            chk("rst_rd_ena", {31'd0, rd_ena_o}, 32'd1);
            chk("rst_org_val", {31'd0, org_val_o}, 32'd0);
            acc_flag = 1'b0;
        end else begin
            if (blk_full && ready_at >= 0 && cyc >= ready_at) begin
                blk_full = 1'b0;
                ready_at = -1;
            end
            exp_rdy  = !blk_full;
            exp_full = blk_full && !(ready_at >= 0 && cyc >= ready_at - 1);
            chk("pix_rdy", {31'd0, pix_rdy_o}, {31'd0, exp_rdy});
            chk("buf_full", {31'd0, buf_full_o}, {31'd0, exp_full});

            exp_rd = ready_at >= 0 && cyc >= ready_at - 17 && cyc <= ready_at - 2;
            chk("rd_ena", {31'd0, rd_ena_o}, {31'd0, !exp_rd});
            if (exp_rd) chk("rd_adr", {28'd0, rd_adr_o}, 32'(cyc - (ready_at - 17)));

            exp_wr = wr_q.size() > 0 && wr_q[0].cyc == cyc;
            chk("wr_ena", {31'd0, wr_ena_o}, {31'd0, !exp_wr});
            if (exp_wr) begin
                e = wr_q.pop_front();
                chk("wr_adr", {28'd0, wr_adr_o}, {28'd0, e.adr});
                chk("wr_dat", wr_dat_o, e.dat);
            end

            exp_org = org_q.size() > 0 && org_q[0].cyc == cyc;
            chk("org_val", {31'd0, org_val_o}, {31'd0, exp_org});
            if (exp_org) begin
                e = org_q.pop_front();
                chk("org_adr", {28'd0, org_adr_o}, {28'd0, e.adr});
                chk("org_dat", org_dat_o, e.dat);
                chk("done", {31'd0, done_o}, {31'd0, e.done});
            end else begin
                chk("done_idle", {31'd0, done_o}, 32'd0);
            end

            // A request only counts while the block is full and not already draining.
            if (rd_req_i && blk_full && ready_at < 0) begin
                for (int i = 0; i < 16; i++) begin
                    e.adr  = 4'(i);
                    e.dat  = mem_m[i];
                    e.done = (i == 15);
                    e.cyc  = cyc + 2 + i;
                    org_q.push_back(e);
                end
                ready_at = cyc + 18;
            end

            acc = pix_val_i && exp_rdy;
            acc_flag = acc;
            if (acc) begin
                px_q.push_back(pix_dat_i);
                if (px_q.size() == 4) begin
                    e.adr  = 4'(wadr_m);
                    e.dat  = {px_q[0], px_q[1], px_q[2], px_q[3]};
                    e.done = 1'b0;
                    e.cyc  = cyc + 1;
                    wr_q.push_back(e);
                    mem_m[wadr_m] = e.dat;
                    px_q.delete();
                    wadr_m++;
                    if (wadr_m == 16) begin
                        wadr_m   = 0;
                        blk_full = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // mode 0: valid held high, 1: valid toggles, 2: random valid. base < 0: random pixels.
    task automatic feed(input int n, input int mode, input int base, input bit hold);
        int cnt = 0;
        int guard = 0;
        logic [7:0] d;
        d = (base < 0) ? 8'($urandom_range(0, 255)) : 8'(base);
        while (cnt < n && guard < 4000) begin
            case (mode)
                0:       pix_val_i = 1'b1;
                1:       pix_val_i = (guard % 2 == 0);
                default: pix_val_i = 1'($urandom_range(0, 1));
            endcase
            pix_dat_i = d;
            @(negedge clk); #1;
            if (acc_flag) begin
                cnt++;
                d = (base < 0) ? 8'($urandom_range(0, 255)) : 8'(base + cnt);
            end
            @(posedge clk); #1;
            guard++;
        end
        if (cnt < n) chk("feed_timeout", 32'(cnt), 32'(n));
        if (hold) begin
            pix_val_i = 1'b1;
            pix_dat_i = d;
        end else begin
            pix_val_i = 1'b0;
        end
    endtask

    task automatic pulse_req();
        rd_req_i = 1'b1;
        @(posedge clk); #1;
        rd_req_i = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        chk("r_pix_rdy", {31'd0, pix_rdy_o}, 32'd1);
        chk("r_buf_full", {31'd0, buf_full_o}, 32'd0);
        chk("r_wr_ena", {31'd0, wr_ena_o}, 32'd1);
        chk("r_rd_ena", {31'd0, rd_ena_o}, 32'd1);
        chk("r_org_val", {31'd0, org_val_o}, 32'd0);
        chk("r_done", {31'd0, done_o}, 32'd0);
        chk("r_wr_adr", {28'd0, wr_adr_o}, 32'd0);
        chk("r_wr_dat", wr_dat_o, 32'd0);
        chk("r_rd_adr", {28'd0, rd_adr_o}, 32'd0);
        chk("r_org_adr", {28'd0, org_adr_o}, 32'd0);
        chk("r_org_dat", org_dat_o, 32'd0);
    endtask

    task automatic mid_reset();
        pix_val_i = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_outputs();
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic full_block(input int mode, input int base);
        feed(64, mode, base, 1'b0);
        wait_cyc(2);
        pulse_req();
        wait_cyc(20);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        for (int i = 0; i < 16; i++) mem_m[i] = 32'd0;
        model_reset();
        wait_cyc(3);
        #1 check_reset_outputs();
        rst = 1'b0;
        @(posedge clk); #1;

        full_block(0, 0);            // sequential 0x00..0x3F
        full_block(1, 0);            // bubbled input, same contents

        feed(20, 2, -1, 1'b0);       // request during fill is ignored
        pulse_req();
        feed(44, 2, -1, 1'b0);
        pulse_req();
        wait_cyc(20);

        full_block(2, -1);

        feed(64, 0, 0, 1'b1);        // back-pressure: pixel 65 waits for the drain
        wait_cyc(3);
        pulse_req();
        feed(64, 0, 64, 1'b0);
        pulse_req();
        wait_cyc(20);

        feed(30, 2, -1, 1'b0);       // reset in the middle of a fill
        mid_reset();
        full_block(2, -1);

        feed(64, 2, -1, 1'b0);       // reset in the middle of a drain
        pulse_req();
        wait_cyc(5);
        mid_reset();
        wait_cyc(20);
        full_block(0, 100);

        wait_cyc(3);
        chk("wr_q_empty", 32'(wr_q.size()), 32'd0);
        chk("org_q_empty", 32'(org_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/prei_org_buf_ctrl.md
Name: prei_org_buf_ctrl

Overview:
- Controller for the 16x32 original-pixel buffer of the pre-intra (prei) stage.
- Upstream side: accepts a raster stream of 8-bit original pixels for one 8x8 block, packs 4 pixels per 32-bit word and drives the buffer's low-active write port.
- Downstream side: on request, drives the buffer's low-active read port in a 16-cycle burst and forwards read words to the prei datapath with a valid strobe.
- Single-buffered; the fill phase and the drain phase of one block are mutually exclusive.

Parameters:
- PIX_WD, 8, bits per pixel (fixed; 4*PIX_WD must equal 32)
- BLK_WORDS, 16, words per block (address width 4)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- pix_val_i  in  1  pixel valid
- pix_dat_i  in  8  pixel, raster order within the 8x8 block
- pix_rdy_o  out  1  controller can accept a pixel
- buf_full_o  out  1  block fully written, not yet drained
- rd_req_i  in  1  single-cycle request to drain the block
- wr_ena_o  out  1  buffer write enable, low active
- wr_adr_o  out  4  buffer write address
- wr_dat_o  out  32  buffer write data
- rd_ena_o  out  1  buffer read enable, low active
- rd_adr_o  out  4  buffer read address
- rd_dat_i  in  32  buffer read data, valid 1 cycle after rd_ena_o low
- org_val_o  out  1  output word valid
- org_adr_o  out  4  word index of org_dat_o
- org_dat_o  out  32  packed 4-pixel word
- done_o  out  1  one-cycle pulse on the last output word

Behaviour:
- States: FILL, FULL, DRAIN. Reset state is FILL.
- Reset values: pix_rdy_o=1, buf_full_o=0, wr_ena_o=1, rd_ena_o=1, org_val_o=0, done_o=0; all address and data outputs and counters = 0; pack register = 0.
- FILL state:
  - pix_rdy_o=1. A pixel is accepted when pix_val_i && pix_rdy_o.
  - Accepted pixels go into a 2-bit lane counter. Lane 0 -> bits [31:24], lane 1 -> [23:16], lane 2 -> [15:8], lane 3 -> [7:0].
  - On accepting lane 3, in the next cycle: wr_ena_o=0, wr_adr_o = word counter, wr_dat_o = completed word. Otherwise wr_ena_o=1.
  - After the write of word 15 (64th pixel accepted), go to FULL.
  - pix_rdy_o drops to 0 in the cycle after the 64th pixel is accepted.
  - Gaps in pix_val_i are allowed; partial words are held indefinitely.
- FULL state:
  - buf_full_o=1, pix_rdy_o=0.
  - rd_req_i=1 -> DRAIN in the next cycle.
- DRAIN state:
  - rd_ena_o=0 for exactly 16 consecutive cycles, rd_adr_o = 0..15.
  - Cycle after each read: org_val_o=1, org_dat_o=rd_dat_i, org_adr_o = address issued the previous cycle.
  - No stall; the consumer must accept 1 word/cycle.
  - done_o=1 coincides with org_adr_o=15.
  - On that same cycle: return to FILL, buf_full_o=0. pix_rdy_o=1 from the following cycle.
  - Total latency from rd_req_i to done_o: 17 cycles.
- rd_req_i outside FULL is ignored. It is not queued.
- wr_ena_o and rd_ena_o are never low in the same cycle. This is structural, since FILL and DRAIN are exclusive.
- Address counters wrap 15->0 at the end of each block.
- Reset asserted mid-FILL or mid-DRAIN:
  - Immediate return to the reset values; partial block discarded.
  - No further write or read strobe occurs after reset assertion.

Test Plan:
- Basic fill: 64 pixels, values 0x00..0x3F, pix_val_i held high -> 16 writes with wr_ena_o=0, adr 0..15. Word 0 = 0x00010203, word 15 = 0x3C3D3E3F. buf_full_o=1 and pix_rdy_o=0 afterwards.
- Drain: rd_req_i pulse after fill, RAM model returns the stored data -> org_val_o high for 16 cycles starting 2 cycles after the pulse, org_adr_o 0..15 with matching data. done_o on 0x3C3D3E3F. pix_rdy_o=1 the cycle after.
- Bubbled input: pix_val_i toggling 1/0 for 64 accepts -> identical RAM contents. Each write occurs exactly one cycle after its 4th-lane accept.
- Ignored request: rd_req_i pulsed during FILL after 20 pixels -> no rd_ena_o activity. The fill completes normally. A later request drains correctly.
- Back-pressure: pix_val_i held high beyond 64 pixels -> pixel 65 not accepted until drain completes. It then lands in word 0, lane 0 of the next block.
- Reset mid-operation: rst asserted at the 30th pixel and again at DRAIN cycle 5 -> outputs return to reset values asynchronously. No strobes follow. A fresh block after release fills from address 0.
